// File: rtl/pca9555_i2c_wr.sv
// pca9555_i2c_wr: I2C master write engine for a PCA9555 port expander.
//
// After reset it writes P_CFG_WORD to the Configuration registers (command
// 0x06), then accepts 16-bit words over valid/ready and writes them to the
// Output Port registers (command 0x02). Each transaction is four bytes:
// address, command, data[7:0], data[15:8]. Every qualified tick
// (tick && synchronized en) advances one quarter-bit phase, so the SCL rate
// is set entirely by the external timer.
//
// Optional build macro: PCA9555_I2C_WR_ACK_CHECK_EN
//   defined   : a NACK sets the sticky nack flag and ends the transfer with STOP
//   undefined : ACK slots are clocked but ignored; nack stays 0
//
// Ports:
//   aclk, reset          clock and synchronous active-high reset
//   tick                 one-cycle timer strobe, one strobe per I2C phase
//   en                   asynchronous enable (2-FF synchronized)
//   s_valid/s_ready      request handshake, s_data {port1, port0}
//   scl_oe, sda_oe       1 pulls the line low, 0 releases it
//   sda_i                SDA line level (2-FF synchronized)
//   busy                 transaction in progress (including init)
//   done                 one-cycle pulse after each STOP
//   nack                 sticky NACK flag, cleared on the next accepted request
//
// state    | meaning
// INIT_REQ | init transaction pending, waits for en_sync
// IDLE     | s_ready high, waiting for a request
// START    | START condition, four phases
// BYTE     | eight data bits, MSB first
// ACK      | ACK slot, SDA released, sampled at p2
// STOP     | STOP condition, four phases
// DONE     | done pulse, then IDLE
module pca9555_i2c_wr #(
  parameter logic [3:0]  P_I2C_ADDRESS_FIXED = 4'b0100,
  parameter logic [2:0]  P_I2C_ADDRESS_PINS  = 3'b000,
  parameter logic [15:0] P_CFG_WORD          = 16'h0000
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic        tick,
  input  logic        en,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_i,
  output logic        busy,
  output logic        done,
  output logic        nack
);

`ifdef PCA9555_I2C_WR_ACK_CHECK_EN
  localparam bit ACK_CHECK = 1'b1;
`else
  localparam bit ACK_CHECK = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_INIT_REQ,
    S_IDLE,
    S_START,
    S_BYTE,
    S_ACK,
    S_STOP,
    S_DONE
  } state_t;

  state_t      state;
  logic [1:0]  en_ff;
  logic [1:0]  sda_ff;
  logic        en_sync;
  logic        sda_sync;
  logic        qtick;
  logic [1:0]  phase;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_cnt;
  logic        is_init;
  logic [15:0] data_q;
  logic        nack_q;
  logic [7:0]  cur_byte;
  logic        cur_bit;

  // Synchronizers carry no reset: they only track asynchronous inputs.
  always_ff @(posedge aclk) begin
    en_ff  <= {en_ff[0], en};
    sda_ff <= {sda_ff[0], sda_i};
  end

  assign en_sync  = en_ff[1];
  assign sda_sync = sda_ff[1];
  assign qtick    = tick & en_sync;
  assign nack     = nack_q;

  always_comb begin
    cur_byte = 8'h00;
    case (byte_cnt)
      2'd0:    cur_byte = {P_I2C_ADDRESS_FIXED, P_I2C_ADDRESS_PINS, 1'b0};
      2'd1:    cur_byte = is_init ? 8'h06 : 8'h02;
      2'd2:    cur_byte = data_q[7:0];
      default: cur_byte = data_q[15:8];
    endcase
  end

  // bit_cnt counts up 0..7, so the MSB-first bit index is 7 - bit_cnt.
  assign cur_bit = cur_byte[~bit_cnt];

  always_ff @(posedge aclk) begin
    if (reset) begin
      state    <= S_INIT_REQ;
      phase    <= 2'd0;
      bit_cnt  <= 3'd0;
      byte_cnt <= 2'd0;
      is_init  <= 1'b1;
      data_q   <= P_CFG_WORD;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b1;
      s_ready  <= 1'b0;
      done     <= 1'b0;
      nack_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_INIT_REQ: begin
          if (en_sync) begin
            state    <= S_START;
            phase    <= 2'd0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 2'd0;
          end
        end

        S_IDLE: begin
          if (s_valid && s_ready) begin
            data_q   <= s_data;
            is_init  <= 1'b0;
            nack_q   <= 1'b0;
            s_ready  <= 1'b0;
            busy     <= 1'b1;
            state    <= S_START;
            phase    <= 2'd0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 2'd0;
          end
        end

        S_DONE: begin
          s_ready <= 1'b1;
          state   <= S_IDLE;
        end

        S_START: begin
          if (qtick) begin
            phase <= phase + 2'd1;
            case (phase)
              2'd0: begin
                scl_oe <= 1'b0;
                sda_oe <= 1'b0;
              end
              2'd1, 2'd2: begin
                scl_oe <= 1'b0;
                sda_oe <= 1'b1;
              end
              default: begin
                scl_oe <= 1'b1;
                sda_oe <= 1'b1;
                state  <= S_BYTE;
              end
            endcase
          end
        end

        S_BYTE: begin
          if (qtick) begin
            phase <= phase + 2'd1;
            case (phase)
              2'd0: begin
                scl_oe <= 1'b1;
                sda_oe <= ~cur_bit;
              end
              2'd1, 2'd2: scl_oe <= 1'b0;
              default: begin
                scl_oe  <= 1'b1;
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state <= S_ACK;
              end
            endcase
          end
        end

        S_ACK: begin
          if (qtick) begin
            phase <= phase + 2'd1;
            case (phase)
              2'd0: begin
                scl_oe <= 1'b1;
                sda_oe <= 1'b0;
              end
              2'd1: scl_oe <= 1'b0;
              2'd2: begin
                scl_oe <= 1'b0;
                if (ACK_CHECK && sda_sync) nack_q <= 1'b1;
              end
              default: begin
                scl_oe <= 1'b1;
                // nack_q is cleared at acceptance, so here it only reflects
                // a NACK seen earlier in this transaction.
                if (byte_cnt == 2'd3 || nack_q) begin
                  state <= S_STOP;
                end else begin
                  byte_cnt <= byte_cnt + 2'd1;
                  state    <= S_BYTE;
                end
              end
            endcase
          end
        end

        S_STOP: begin
          if (qtick) begin
            phase <= phase + 2'd1;
            case (phase)
              2'd0: begin
                scl_oe <= 1'b1;
                sda_oe <= 1'b1;
              end
              2'd1: begin
                scl_oe <= 1'b0;
                sda_oe <= 1'b1;
              end
              2'd2: begin
                scl_oe <= 1'b0;
                sda_oe <= 1'b0;
              end
              default: begin
                scl_oe <= 1'b0;
                sda_oe <= 1'b0;
                done   <= 1'b1;
                busy   <= 1'b0;
                state  <= S_DONE;
              end
            endcase
          end
        end

        default: state <= S_INIT_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_pca9555_i2c_wr.sv
module tb_pca9555_i2c_wr;

  logic        aclk;
  logic        reset;
  logic        tick;
  logic        en;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        scl_oe;
  logic        sda_oe;
  logic        sda_i;
  logic        busy;
  logic        done;
  logic        nack;

  int total = 0;
  int bad   = 0;

  pca9555_i2c_wr dut (
    .aclk    (aclk),
    .reset   (reset),
    .tick    (tick),
    .en      (en),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .scl_oe  (scl_oe),
    .sda_oe  (sda_oe),
    .sda_i   (sda_i),
    .busy    (busy),
    .done    (done),
    .nack    (nack)
  );

  initial begin
    aclk = 1'b0;
    forever #20 aclk = ~aclk;
  end

  // tick generator: one strobe every 4 cycles while tick_on
  bit tick_on = 1'b0;
  int tcnt = 0;
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge aclk);
      tcnt++;
      tick = tick_on && (tcnt % 4 == 0);
    end
  end

  // qualified tick count, en delayed through two stages like the DUT sees it
  int   qcnt = 0;
  int   cyc  = 0;
  logic en_d1 = 1'b0;
  logic en_d2 = 1'b0;
  always @(posedge aclk) begin
    cyc++;
    if (tick && en_d2) qcnt++;
    en_d1 <= en;
    en_d2 <= en_d1;
  end

  // bus and PCA9555 slave model
  logic       slave_pull = 1'b0;
  logic       scl_bus, sda_bus;
  logic       scl_d = 1'b1;
  logic       sda_d = 1'b1;
  int         bitn = 0;
  int         bytes_seen = 0;
  int         nack_idx = -1;
  int         last_n = 0;
  int         starts = 0;
  logic [7:0] shreg = 8'h00;
  logic [7:0] rx [4];
  logic [31:0] last_word = 32'h0;
  logic [7:0] io0 = 8'hFF, io1 = 8'hFF, cfg0 = 8'hFF, cfg1 = 8'hFF;

  assign scl_bus = ~scl_oe;
  assign sda_bus = ~(sda_oe | slave_pull);
  assign sda_i   = sda_bus;

  always @(posedge aclk) begin
    scl_d <= scl_bus;
    sda_d <= sda_bus;
    if (scl_bus && scl_d && sda_d && !sda_bus) begin
      starts++;
      bitn = 0;
      bytes_seen = 0;
      slave_pull <= 1'b0;
    end else if (scl_bus && scl_d && !sda_d && sda_bus) begin
      last_n = bytes_seen;
      last_word = {rx[0], rx[1], rx[2], rx[3]};
      if (bytes_seen == 4 && rx[0] == 8'h40) begin
        if (rx[1] == 8'h02) begin io0 = rx[2]; io1 = rx[3]; end
        if (rx[1] == 8'h06) begin cfg0 = rx[2]; cfg1 = rx[3]; end
      end
      bytes_seen = 0;
      bitn = 0;
    end else if (scl_bus && !scl_d) begin
      if (bitn < 8) shreg = {shreg[6:0], sda_bus};
      bitn++;
    end else if (!scl_bus && scl_d) begin
      if (bitn == 8) begin
        if (bytes_seen < 4) rx[bytes_seen] = shreg;
        slave_pull <= (bytes_seen != nack_idx);
        bytes_seen++;
      end else if (bitn == 9) begin
        slave_pull <= 1'b0;
        bitn = 0;
      end
    end
  end

  int q_acc;

  task automatic send(input logic [15:0] d, input bit hold, output bit ok);
    ok = 1'b0;
    s_data = d;
    s_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (s_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge aclk);
    end
    if (ok) @(negedge aclk);
    if (!hold) s_valid = 1'b0;
    q_acc = qcnt;
  endtask

  task automatic wait_done(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge aclk);
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge aclk);
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (nack !== 1'b0) begin bad++; $display("FAIL reset_nack got=%b exp=0", nack); end
    total++; if ({scl_oe, sda_oe} !== 2'b00) begin bad++; $display("FAIL reset_oe got=%b exp=00", {scl_oe, sda_oe}); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", busy); end
  endtask

  task automatic test_init;
    int q0;
    bit seen;
    reset = 1'b0;
    repeat (3) @(negedge aclk);
    q0 = qcnt;
    tick_on = 1'b1;
    wait_done(2000, seen);
    total++; if (!seen) begin bad++; $display("FAIL init_done_timeout got=0 exp=1"); end
    total++; if (qcnt - q0 !== 152) begin bad++; $display("FAIL init_ticks got=%0d exp=152", qcnt - q0); end
    total++; if (last_word !== 32'h40060000 || last_n !== 4) begin bad++; $display("FAIL init_bytes got=%h n=%0d exp=40060000 n=4", last_word, last_n); end
    total++; if ({cfg1, cfg0} !== 16'h0000) begin bad++; $display("FAIL init_cfg got=%h exp=0000", {cfg1, cfg0}); end
    total++; if (busy !== 1'b0 || s_ready !== 1'b0) begin bad++; $display("FAIL init_busy_ready got=%b%b exp=00", busy, s_ready); end
    @(negedge aclk);
    total++; if (done !== 1'b0 || s_ready !== 1'b1) begin bad++; $display("FAIL init_after_done got=%b%b exp=01", done, s_ready); end
  endtask

  task automatic test_user_write;
    bit ok, seen;
    send(16'hA55A, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL user_accept_timeout got=0 exp=1"); end
    total++; if (s_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL user_accept_flags got=%b%b exp=01", s_ready, busy); end
    wait_done(2000, seen);
    total++; if (!seen) begin bad++; $display("FAIL user_done_timeout got=0 exp=1"); end
    total++; if (qcnt - q_acc !== 152) begin bad++; $display("FAIL user_ticks got=%0d exp=152", qcnt - q_acc); end
    total++; if (last_word !== 32'h40025AA5) begin bad++; $display("FAIL user_bytes got=%h exp=40025aa5", last_word); end
    total++; if ({io1, io0} !== 16'hA55A) begin bad++; $display("FAIL user_io got=%h exp=a55a", {io1, io0}); end
    @(negedge aclk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL user_done_width got=%b exp=0", done); end
  endtask

  task automatic test_en_freeze;
    bit ok, seen, changed;
    logic s_scl, s_sda;
    send(16'h1234, 1'b0, ok);
    for (int i = 0; i < 2000 && (qcnt - q_acc) != 22; i++) @(negedge aclk);
    en = 1'b0;
    repeat (3) @(negedge aclk);
    s_scl = scl_oe;
    s_sda = sda_oe;
    changed = 1'b0;
    for (int i = 0; i < 160; i++) begin
      @(negedge aclk);
      if (scl_oe !== s_scl || sda_oe !== s_sda) changed = 1'b1;
    end
    total++; if (changed) begin bad++; $display("FAIL en_freeze_oe got=changed exp=held %b%b", s_scl, s_sda); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL en_freeze_busy got=%b exp=1", busy); end
    en = 1'b1;
    wait_done(2000, seen);
    total++; if (!seen) begin bad++; $display("FAIL en_done_timeout got=0 exp=1"); end
    total++; if (qcnt - q_acc !== 152) begin bad++; $display("FAIL en_ticks got=%0d exp=152", qcnt - q_acc); end
    total++; if (last_word !== 32'h40023412) begin bad++; $display("FAIL en_bytes got=%h exp=40023412", last_word); end
    @(negedge aclk);
  endtask

  task automatic test_nack;
    bit ok, seen;
    nack_idx = 1;
    send(16'h0F0F, 1'b0, ok);
    wait_done(2000, seen);
    nack_idx = -1;
    total++; if (!seen) begin bad++; $display("FAIL nack_done_timeout got=0 exp=1"); end
`ifdef PCA9555_I2C_WR_ACK_CHECK_EN
    total++; if (nack !== 1'b1) begin bad++; $display("FAIL nack_flag got=%b exp=1", nack); end
    total++; if (last_n !== 2) begin bad++; $display("FAIL nack_bytes got=%0d exp=2", last_n); end
    total++; if (qcnt - q_acc !== 80) begin bad++; $display("FAIL nack_ticks got=%0d exp=80", qcnt - q_acc); end
`else
    total++; if (nack !== 1'b0) begin bad++; $display("FAIL nack_flag got=%b exp=0", nack); end
    total++; if (last_n !== 4) begin bad++; $display("FAIL nack_bytes got=%0d exp=4", last_n); end
    total++; if (qcnt - q_acc !== 152) begin bad++; $display("FAIL nack_ticks got=%0d exp=152", qcnt - q_acc); end
`endif
    @(negedge aclk);
    send(16'h3C3C, 1'b0, ok);
    total++; if (nack !== 1'b0) begin bad++; $display("FAIL nack_clear got=%b exp=0", nack); end
    wait_done(2000, seen);
    total++; if ({io1, io0} !== 16'h3C3C || nack !== 1'b0) begin bad++; $display("FAIL nack_followup got=%h/%b exp=3c3c/0", {io1, io0}, nack); end
    @(negedge aclk);
  endtask

  task automatic test_back_to_back;
    bit ok, seen;
    int t_done;
    send(16'h0001, 1'b1, ok);
    s_data = 16'h8000;
    wait_done(2000, seen);
    t_done = cyc;
    total++; if (!seen || {io1, io0} !== 16'h0001) begin bad++; $display("FAIL b2b_first got=%h exp=0001", {io1, io0}); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_at_done got=%b exp=0", s_ready); end
    send(16'h8000, 1'b0, ok);
    total++; if (!ok || (cyc - t_done) < 2) begin bad++; $display("FAIL b2b_gap got=%0d exp>=2", cyc - t_done); end
    wait_done(2000, seen);
    total++; if (!seen || {io1, io0} !== 16'h8000) begin bad++; $display("FAIL b2b_second got=%h exp=8000", {io1, io0}); end
    total++; if (last_word !== 32'h40020080) begin bad++; $display("FAIL b2b_bytes got=%h exp=40020080", last_word); end
    @(negedge aclk);
  endtask

  task automatic test_reset_mid;
    bit ok, seen, hit;
    int s0;
    send(16'hBEEF, 1'b0, ok);
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge aclk);
      if (bytes_seen == 2 && bitn == 4) hit = 1'b1;
    end
    total++; if (!hit) begin bad++; $display("FAIL mid_reach_timeout got=0 exp=1"); end
    s0 = starts;
    reset = 1'b1;
    @(negedge aclk);
    total++; if ({scl_oe, sda_oe} !== 2'b00 || busy !== 1'b1) begin bad++; $display("FAIL mid_reset_out got=oe%b%b busy%b exp=oe00 busy1", scl_oe, sda_oe, busy); end
    reset = 1'b0;
    wait_done(2000, seen);
    total++; if (!seen || starts - s0 !== 1) begin bad++; $display("FAIL mid_restart got=seen%b starts%0d exp=1/1", seen, starts - s0); end
    total++; if (last_word !== 32'h40060000 || last_n !== 4) begin bad++; $display("FAIL mid_init_bytes got=%h exp=40060000", last_word); end
    total++; if ({io1, io0} !== 16'h8000) begin bad++; $display("FAIL mid_io_kept got=%h exp=8000", {io1, io0}); end
    @(negedge aclk);
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", s_ready); end
  endtask

  initial begin
    reset   = 1'b1;
    en      = 1'b1;
    s_valid = 1'b0;
    s_data  = 16'h0000;
    test_reset;
    test_init;
    test_user_write;
    test_en_freeze;
    test_nack;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
